// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Writeback result-select codes and load funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam logic [1:0] c_wbsel_alu  = 2'b00;
    localparam logic [1:0] c_wbsel_load = 2'b01;
    localparam logic [1:0] c_wbsel_pc4  = 2'b10;
    localparam logic [1:0] c_wbsel_imm  = 2'b11;

    localparam logic [2:0] c_ld_lb  = 3'b000;
    localparam logic [2:0] c_ld_lh  = 3'b001;
    localparam logic [2:0] c_ld_lw  = 3'b010;
    localparam logic [2:0] c_ld_lbu = 3'b100;
    localparam logic [2:0] c_ld_lhu = 3'b101;

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Extracts byte/half from an aligned load word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import wb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] word,
    input  logic [1:0]   off,
    input  logic [2:0]   ldtype,
    output logic [N-1:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (off)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        // Halfword uses only off[1]; a misaligned off[0] is ignored.
        w_half = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        value = word;
        case (ldtype)
            c_ld_lb:  value = {{(N-8){w_byte[7]}}, w_byte};
            c_ld_lbu: value = {{(N-8){1'b0}}, w_byte};
            c_ld_lh:  value = {{(N-16){w_half[15]}}, w_half};
            c_ld_lhu: value = {{(N-16){1'b0}}, w_half};
            default:  value = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : MEM/WB register, result select, register-file write and bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 5,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic          mem_regwrite,
    input  logic [AW-1:0] mem_rd,
    input  logic [1:0]    mem_wbsel,
    input  logic [2:0]    mem_ldtype,
    input  logic [N-1:0]  mem_alu,
    input  logic [N-1:0]  mem_load,
    input  logic [N-1:0]  mem_pc4,
    input  logic [N-1:0]  mem_imm,
    input  logic          wb_stall,
    input  logic          wb_flush,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [N-1:0]  rf_wdata,
    output logic          fwd1_hit,
    output logic [N-1:0]  fwd1_data,
    output logic          fwd2_hit,
    output logic [N-1:0]  fwd2_data,
    output logic [CW-1:0] retire_cnt
);

    logic          r_valid;
    logic          r_regwrite;
    logic [AW-1:0] r_rd;
    logic [N-1:0]  r_wdata;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  w_load_fmt;
    logic [N-1:0]  w_result;

    load_extend #(.N(N)) u_load_extend (
        .word   (mem_load),
        .off    (mem_alu[1:0]),
        .ldtype (mem_ldtype),
        .value  (w_load_fmt)
    );

    always_comb begin
        w_result = mem_alu;
        case (mem_wbsel)
            c_wbsel_alu:  w_result = mem_alu;
            c_wbsel_load: w_result = w_load_fmt;
            c_wbsel_pc4:  w_result = mem_pc4;
            default:      w_result = mem_imm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
        end else begin
            // Flush kills the incoming slot even while stalled; data is left as-is.
            if (wb_flush) begin
                r_valid <= 1'b0;
            end else if (!wb_stall) begin
                r_valid    <= mem_valid;
                r_regwrite <= mem_regwrite;
                r_rd       <= mem_rd;
                r_wdata    <= w_result;
            end
            if (r_valid && !wb_stall) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign rf_we      = r_valid & r_regwrite & (r_rd != '0) & ~wb_stall;
    assign rf_waddr   = r_rd;
    assign rf_wdata   = r_wdata;
    assign retire_cnt = r_cnt;

    // rf_we already excludes r0, so an id_rs of zero can never match.
    assign fwd1_hit  = rf_we & (r_rd == id_rs1);
    assign fwd2_hit  = rf_we & (r_rd == id_rs2);
    assign fwd1_data = fwd1_hit ? r_wdata : '0;
    assign fwd2_data = fwd2_hit ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed plus randomized checks of wb_stage against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valid, mem_regwrite;
    logic [AW-1:0] mem_rd;
    logic [1:0]    mem_wbsel;
    logic [2:0]    mem_ldtype;
    logic [N-1:0]  mem_alu, mem_load, mem_pc4, mem_imm;
    logic          wb_stall, wb_flush;
    logic [AW-1:0] id_rs1, id_rs2;
    logic          rf_we, fwd1_hit, fwd2_hit;
    logic [AW-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata, fwd1_data, fwd2_data;
    logic [CW-1:0] retire_cnt;

    int tests = 0;
    int fails = 0;

    // Reference state: the instruction currently sitting in writeback.
    bit          m_valid;
    bit          m_regwrite;
    int unsigned m_rd;
    logic [31:0] m_wdata;
    int unsigned m_retired;

    wb_stage #(.N(N), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_wbsel(mem_wbsel), .mem_ldtype(mem_ldtype), .mem_alu(mem_alu),
        .mem_load(mem_load), .mem_pc4(mem_pc4), .mem_imm(mem_imm),
        .wb_stall(wb_stall), .wb_flush(wb_flush), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] load_value(logic [31:0] w, logic [1:0] off, logic [2:0] t);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (t)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] result_value();
        case (mem_wbsel)
            2'd0:    return mem_alu;
            2'd1:    return load_value(mem_load, mem_alu[1:0], mem_ldtype);
            2'd2:    return mem_pc4;
            default: return mem_imm;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        bit writes, h1, h2;
        writes = m_valid && m_regwrite && (m_rd != 0) && !wb_stall;
        h1 = writes && (m_rd == id_rs1);
        h2 = writes && (m_rd == id_rs2);
        chk("rf_we",      32'(rf_we),      32'(writes));
        chk("rf_waddr",   32'(rf_waddr),   m_rd);
        chk("rf_wdata",   rf_wdata,        m_wdata);
        chk("fwd1_hit",   32'(fwd1_hit),   32'(h1));
        chk("fwd1_data",  fwd1_data,       h1 ? m_wdata : 32'h0);
        chk("fwd2_hit",   32'(fwd2_hit),   32'(h2));
        chk("fwd2_data",  fwd2_data,       h2 ? m_wdata : 32'h0);
        chk("retire_cnt", 32'(retire_cnt), m_retired % (1 << CW));
    endtask

    // Check the current cycle, then advance the model across the clock edge.
    task automatic cycle();
        logic [31:0] res;
        #1;
        check_all();
        res = result_value();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_regwrite = 0; m_rd = 0; m_wdata = 0; m_retired = 0;
        end else begin
            if (m_valid && !wb_stall) m_retired++;
            if (wb_flush) m_valid = 0;
            else if (!wb_stall) begin
                m_valid = mem_valid; m_regwrite = mem_regwrite;
                m_rd = mem_rd; m_wdata = res;
            end
        end
        #1;
    endtask

    task automatic issue(input bit v, input bit rw, input int unsigned rd,
                         input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] alu);
        mem_valid = v; mem_regwrite = rw; mem_rd = AW'(rd);
        mem_wbsel = sel; mem_ldtype = lt; mem_alu = alu;
    endtask

    initial begin
        rst = 1; wb_stall = 0; wb_flush = 0; id_rs1 = 0; id_rs2 = 0;
        issue(0, 0, 0, 2'd0, 3'd2, 32'h0);
        mem_load = 32'h80FF7F01; mem_pc4 = 32'h104; mem_imm = 32'hABCDE000;
        m_valid = 0; m_regwrite = 0; m_rd = 0; m_wdata = 0; m_retired = 0;
        @(posedge clk); #1;
        cycle();
        chk("reset_we", 32'(rf_we), 32'h0);
        rst = 0;

        // ALU write to x5
        issue(1, 1, 5, 2'd0, 3'd2, 32'h1234);
        cycle();
        issue(0, 0, 0, 2'd0, 3'd2, 32'h0);
        #1;
        chk("alu_we", 32'(rf_we), 32'h1);
        chk("alu_waddr", 32'(rf_waddr), 32'h5);
        chk("alu_wdata", rf_wdata, 32'h1234);
        cycle();
        chk("alu_cnt", 32'(retire_cnt), 32'h1);

        // r0 guard
        issue(1, 1, 0, 2'd0, 3'd2, 32'hFFFF);
        cycle();
        id_rs1 = 0;
        #1;
        chk("r0_we", 32'(rf_we), 32'h0);
        chk("r0_fwd1", 32'(fwd1_hit), 32'h0);
        issue(1, 1, 6, 2'd1, 3'd0, 32'h3);           // LB off=3
        cycle();
        chk("lb_off3", rf_wdata, 32'hFFFFFF80);
        issue(1, 1, 6, 2'd1, 3'd4, 32'h1);           // LBU off=1
        cycle();
        chk("lbu_off1", rf_wdata, 32'h0000007F);
        issue(1, 1, 6, 2'd1, 3'd1, 32'h2);           // LH off=2
        cycle();
        chk("lh_off2", rf_wdata, 32'hFFFF80FF);
        issue(1, 1, 6, 2'd1, 3'd5, 32'h1);           // LHU off=1
        cycle();
        chk("lhu_off1", rf_wdata, 32'h00007F01);
        issue(1, 1, 6, 2'd1, 3'd2, 32'h3);           // LW ignores offset
        cycle();
        chk("lw_off3", rf_wdata, 32'h80FF7F01);

        // Stall for two cycles with rd=7 in WB
        issue(1, 1, 7, 2'd0, 3'd2, 32'h77);
        cycle();
        issue(1, 1, 8, 2'd0, 3'd2, 32'h88);
        wb_stall = 1;
        cycle();
        chk("stall1_waddr", 32'(rf_waddr), 32'h7);
        cycle();
        chk("stall2_waddr", 32'(rf_waddr), 32'h7);
        wb_flush = 1;
        cycle();
        wb_stall = 0; wb_flush = 0;
        issue(0, 0, 0, 2'd0, 3'd2, 32'h0);
        #1;
        chk("stallflush_we", 32'(rf_we), 32'h0);
        cycle();

        // Bypass from x9
        issue(1, 1, 9, 2'd0, 3'd2, 32'hDEADBEEF);
        cycle();
        id_rs1 = 9; id_rs2 = 3;
        #1;
        chk("byp_hit1", 32'(fwd1_hit), 32'h1);
        chk("byp_data1", fwd1_data, 32'hDEADBEEF);
        chk("byp_hit2", 32'(fwd2_hit), 32'h0);
        chk("byp_data2", fwd2_data, 32'h0);
        cycle();

        // Counter wrap after 16 retirements
        rst = 1;
        cycle();
        rst = 0;
        issue(1, 1, 4, 2'd2, 3'd2, 32'h0);
        for (int i = 0; i < 17; i++) cycle();
        chk("wrap_cnt", 32'(retire_cnt), 32'h0);

        // Randomized traffic with occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            wb_stall  = ($urandom_range(0, 4) == 0);
            wb_flush  = ($urandom_range(0, 6) == 0);
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), $urandom);
            mem_load = $urandom; mem_pc4 = $urandom; mem_imm = $urandom;
            id_rs1 = ($urandom_range(0, 1) == 1) ? AW'(m_rd) : AW'($urandom_range(0, 31));
            id_rs2 = ($urandom_range(0, 2) == 1) ? AW'(m_rd) : AW'($urandom_range(0, 31));
            cycle();
        end

        // Reset while stalled and flushing clears everything
        issue(1, 1, 12, 2'd3, 3'd2, 32'h0);
        wb_stall = 0; wb_flush = 0; rst = 0;
        cycle();
        rst = 1; wb_stall = 1; wb_flush = 1;
        cycle();
        rst = 0; wb_stall = 0; wb_flush = 0;
        #1;
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_waddr", 32'(rf_waddr), 32'h0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_cnt", 32'(retire_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
